// File: rtl/ctrl_multiciclo.sv
// Control FSM for the multicycle MIPS-subset datapath.
// Fetch/decode/execute/memory/writeback sequencing with memory-ready stalls.
module ctrl_multiciclo #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       sel_dest,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12
  } state_t;

  state_t cur, nxt;

  always_ff @(posedge clk) begin
    if (reset) cur <= S_RST;
    else       cur <= nxt;
  end

  assign state = cur;

  always_comb begin
    nxt           = cur;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    sel_dest      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    unique case (cur)
      S_RST: nxt = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC load only on the cycle the fetch completes
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):     nxt = S_MEMADR;
          (opcode == OP_RTYPE):  nxt = S_EXEC;
          (opcode == OP_BEQ):    nxt = S_BRANCH;
          (opcode == OP_J):      nxt = S_JUMP;
          (opcode == OP_ADDI):   nxt = S_IEXEC;
          default: begin
            illegal_op = 1'b1;
            nxt        = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) nxt = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt       = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        sel_dest  = 1'b1;
        nxt       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        nxt           = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        nxt       = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        nxt       = S_FETCH;
      end
      default: nxt = S_RST;
    endcase
  end

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Bench for ctrl_multiciclo: instruction-route model checked every cycle,
// plus directed literal checks of traces, stall lengths and reset.
module tb_ctrl_multiciclo;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, sel_dest, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       illegal_op;
  logic [3:0] state;

  ctrl_multiciclo dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .sel_dest(sel_dest), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit en = 1'b0;

  typedef struct packed {
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, sel_dest, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op;
  } ctl_t;

  function automatic ctl_t expect_ctl(int code, logic [5:0] op, logic rdy);
    ctl_t c = '0;
    case (code)
      1:  begin c.mem_read = 1; c.alu_src_b = 2'b01;
                c.ir_write = rdy; c.pc_write = rdy; end
      2:  begin c.alu_src_b = 2'b11;
                c.illegal_op = !(op inside {6'h00, 6'h23, 6'h2b,
                                            6'h04, 6'h08, 6'h02}); end
      3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4:  begin c.mem_read = 1; c.i_or_d = 1; end
      5:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      6:  begin c.mem_write = 1; c.i_or_d = 1; end
      7:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      8:  begin c.reg_write = 1; c.sel_dest = 1; end
      9:  begin c.alu_src_a = 1; c.alu_op = 2'b01;
                c.pc_write_cond = 1; c.pc_source = 2'b01; end
      10: begin c.pc_write = 1; c.pc_source = 2'b10; end
      11: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      12: begin c.reg_write = 1; end
      default: ;
    endcase
    return c;
  endfunction

  // Model: current step plus remaining route of the decoded instruction
  int m_code = 0;
  int m_seq[$];

  always @(posedge clk) begin
    if (reset) begin
      m_code = 0;
      m_seq.delete();
    end else if (m_code == 0) begin
      m_code = 1;
    end else if (m_code == 1) begin
      if (mem_ready) m_code = 2;
    end else begin
      if (m_code == 2) begin
        m_seq.delete();
        case (opcode)
          6'h23: m_seq = '{3, 4, 5};
          6'h2b: m_seq = '{3, 6};
          6'h00: m_seq = '{7, 8};
          6'h04: m_seq = '{9};
          6'h02: m_seq = '{10};
          6'h08: m_seq = '{11, 12};
          default: ;
        endcase
      end
      if (!((m_code == 4 || m_code == 6) && !mem_ready))
        m_code = (m_seq.size() > 0) ? m_seq.pop_front() : 1;
    end
  end

  always @(negedge clk) begin : cmp
    ctl_t a, e;
    if (en) begin
      a = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, sel_dest, reg_write, alu_src_a,
           alu_src_b, alu_op, pc_source, illegal_op};
      e = expect_ctl(m_code, opcode, mem_ready);
      checks++;
      if (state !== m_code[3:0]) begin
        errors++;
        $display("FAIL model_state t=%0t got %0d expected %0d",
                 $time, state, m_code);
      end
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL model_outs t=%0t state=%0d got %b expected %b",
                 $time, m_code, a, e);
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int tr[5];
  int exp_r[5] = '{1, 2, 7, 8, 1};
  int cnt;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    opcode = 6'b000000;
    mem_ready = 1'b1;
    @(posedge clk);
    en = 1'b1;
    step();
    chk("rst_state", int'(state), 0);
    chk("rst_outs", int'({pc_write, pc_write_cond, i_or_d, mem_read,
        mem_write, ir_write, mem_to_reg, sel_dest, reg_write, alu_src_a,
        alu_src_b, alu_op, pc_source, illegal_op}), 0);
    reset = 1'b0;
    step();
    chk("fetch_state", int'(state), 1);
    chk("fetch_mem_read", int'(mem_read), 1);
    chk("fetch_alu_src_b", int'(alu_src_b), 1);

    // R-type trace
    for (int i = 0; i < 5; i++) begin
      tr[i] = int'(state);
      if (state == 4'd8) begin
        chk("rwb_reg_write", int'(reg_write), 1);
        chk("rwb_sel_dest", int'(sel_dest), 1);
        chk("rwb_mem_to_reg", int'(mem_to_reg), 0);
      end
      if (i < 4) step();
    end
    for (int i = 0; i < 5; i++) chk("rtype_trace", tr[i], exp_r[i]);

    // LW with three stall cycles in MEMRD
    opcode = 6'b100011;
    step();
    step();
    mem_ready = 1'b0;
    step();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (state != 4'd4) break;
      cnt++;
      chk("memrd_mem_read", int'(mem_read), 1);
      chk("memrd_i_or_d", int'(i_or_d), 1);
      if (cnt == 4) mem_ready = 1'b1;
      step();
    end
    chk("memrd_cycles", cnt, 4);
    chk("memwb_state", int'(state), 5);
    chk("memwb_reg_write", int'(reg_write), 1);
    chk("memwb_sel_dest", int'(sel_dest), 0);
    chk("memwb_mem_to_reg", int'(mem_to_reg), 1);
    step();
    chk("lw_back_fetch", int'(state), 1);

    // SW
    opcode = 6'b101011;
    step(); step(); step();
    chk("memwr_state", int'(state), 6);
    chk("memwr_mem_write", int'(mem_write), 1);
    chk("memwr_reg_write", int'(reg_write), 0);
    step();
    chk("sw_back_fetch", int'(state), 1);

    // BEQ
    opcode = 6'b000100;
    step(); step();
    chk("branch_state", int'(state), 9);
    chk("branch_pwc", int'(pc_write_cond), 1);
    chk("branch_alu_op", int'(alu_op), 1);
    chk("branch_pc_source", int'(pc_source), 1);
    step();
    chk("beq_back_fetch", int'(state), 1);

    // J and ADDI, with opcode changed mid-instruction for ADDI
    opcode = 6'b000010;
    step(); step();
    chk("jump_pc_source", int'(pc_source), 2);
    step();
    chk("j_back_fetch", int'(state), 1);
    opcode = 6'b001000;
    step(); step();
    opcode = 6'b000000;
    step();
    chk("iwb_state", int'(state), 12);
    step();
    chk("addi_back_fetch", int'(state), 1);

    // Illegal opcode
    opcode = 6'b111111;
    step();
    chk("illegal_pulse", int'(illegal_op), 1);
    chk("illegal_no_reg_write", int'(reg_write), 0);
    chk("illegal_no_mem_write", int'(mem_write), 0);
    step();
    chk("illegal_back_fetch", int'(state), 1);
    chk("illegal_cleared", int'(illegal_op), 0);

    // Reset during a stalled store
    opcode = 6'b101011;
    step(); step();
    mem_ready = 1'b0;
    step(); step();
    chk("memwr_wait_state", int'(state), 6);
    reset = 1'b1;
    step();
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_mem_write", int'(mem_write), 0);
    reset = 1'b0;
    step();
    step();
    chk("fetch_stall_state", int'(state), 1);
    chk("fetch_stall_ir_write", int'(ir_write), 0);
    mem_ready = 1'b1;
    #1;
    chk("fetch_ready_ir_write", int'(ir_write), 1);
    step();
    opcode = 6'b000000;
    step(); step(); step();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_multiciclo.md
Name: ctrl_multiciclo

Overview:
- Moore/Mealy control FSM for the multicycle MIPS-subset datapath.
- Sequences fetch, decode, execute, memory and writeback.
- Drives register-destination select `sel_dest` (rt/rd mux), register-file write enable, ALU operand/opcode selects, PC update and memory strobes.
- Stalls on a memory ready handshake.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch equal
- OP_ADDI, 6'b001000, add immediate
- OP_J, 6'b000010, jump

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instruction[31:26] from IR
- mem_ready  in  1  memory completes access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  0=PC address, 1=ALUOut address
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- mem_to_reg  out  1  0=ALUOut, 1=MDR to register file
- sel_dest  out  1  0=rt, 1=rd as write register
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=funct-decoded
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- illegal_op  out  1  one-cycle pulse on undefined opcode
- state  out  4  current state code, debug

Behaviour:
- States (code):
  - RST(0)
  - FETCH(1)
  - DECODE(2)
  - MEMADR(3)
  - MEMRD(4)
  - MEMWB(5)
  - MEMWR(6)
  - EXEC(7)
  - RWB(8)
  - BRANCH(9)
  - JUMP(10)
  - IEXEC(11)
  - IWB(12)
- reset=1 at a clock edge → state=RST next cycle, regardless of current state (including mid-memory-access).
- In RST all outputs are 0. Unlisted outputs are 0 in every state.
- RST→FETCH unconditionally.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write = mem_ready (Mealy).
  - Stay while mem_ready=0; →DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Transition on opcode:
  - LW/SW→MEMADR
  - RTYPE→EXEC
  - BEQ→BRANCH
  - J→JUMP
  - ADDI→IEXEC
  - other→FETCH with illegal_op=1 for this cycle only; no register or memory write.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. →MEMRD if LW, →MEMWR if SW.
- MEMRD: mem_read=1, i_or_d=1. Wait for mem_ready, then →MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, sel_dest=0. →FETCH.
- MEMWR: mem_write=1, i_or_d=1. Wait for mem_ready, then →FETCH. mem_write stays high through the wait.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. →RWB.
- RWB: reg_write=1, sel_dest=1, mem_to_reg=0. →FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. →FETCH.
- JUMP: pc_write=1, pc_source=10. →FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10, alu_op=00. →IWB.
- IWB: reg_write=1, sel_dest=0, mem_to_reg=0. →FETCH.
- Invariants:
  - reg_write=1 only in MEMWB, RWB, IWB.
  - sel_dest=1 only in RWB.
  - mem_read and mem_write never both 1.
- opcode is sampled only in DECODE and MEMADR. IR is stable after FETCH, so opcode changes elsewhere have no effect.
- Cycle counts with mem_ready always 1: R-type 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4.
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.

Test Plan:
- reset=1 for 2 cycles → state=0, all outputs 0; release → FETCH next cycle, then mem_read=1, alu_src_b=01.
- opcode=000000, mem_ready=1 → states 1,2,7,8,1; in state 8 reg_write=1, sel_dest=1, mem_to_reg=0.
- opcode=100011, mem_ready low for 3 cycles in MEMRD → MEMRD held 4 cycles with mem_read=1, i_or_d=1; then MEMWB with reg_write=1, sel_dest=0, mem_to_reg=1.
- opcode=101011 → MEMWR mem_write=1, reg_write=0 throughout; opcode=000100 → BRANCH pc_write_cond=1, alu_op=01, pc_source=01.
- opcode=111111 → illegal_op pulses 1 cycle in DECODE, returns to FETCH, no reg_write/mem_write asserted.
- reset asserted during MEMWR wait (mem_ready=0) → next cycle state=0, mem_write=0.
